// File: rtl/seq_tx_if.sv
// seq_tx_if: parallel load side and serial output side of the bit-serial transmitter
interface seq_tx_if #(parameter int WIDTH = 8);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ready;
    logic             a;
    logic             valid;
    logic             last;
    modport master (output load, data, input ready, a, valid, last);
    modport slave  (input load, data, output ready, a, valid, last);
endinterface

// File: rtl/seq_tx.sv
// seq_tx: Moore FSM that shifts a captured word out on a, one bit per clock, then idles GAP cycles
module seq_tx #(
    parameter int WIDTH     = 8,
    parameter int GAP       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic   clk,
    input logic   reset,
    seq_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, S_GAP = 2'd2} state_t;
    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_sr, w_sr;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [GW-1:0]    r_gcnt, w_gcnt;
    logic             r_a, r_valid, r_last, r_ready;
    logic             w_head;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_a     <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state;
            r_sr    <= w_sr;
            r_cnt   <= w_cnt;
            r_gcnt  <= w_gcnt;
            // outputs are registered from the next state so they change only on the edge
            r_ready <= w_state == IDLE;
            r_valid <= w_state == SHIFT;
            r_a     <= (w_state == SHIFT) && w_head;
            r_last  <= (w_state == SHIFT) && (w_cnt == '0);
        end
    end
    always_comb begin
        w_state = r_state;
        w_sr    = r_sr;
        w_cnt   = r_cnt;
        w_gcnt  = r_gcnt;
        case (r_state)
            IDLE: if (bus.load) begin
                w_sr    = bus.data;
                w_cnt   = CW'(WIDTH - 1);
                w_state = SHIFT;
            end
            SHIFT: if (r_cnt != '0) begin
                w_sr  = MSB_FIRST ? (r_sr << 1) : (r_sr >> 1);
                w_cnt = r_cnt - 1'b1;
            end else if (GAP > 0) begin
                w_state = S_GAP;
                w_gcnt  = GW'(GAP - 1);
            end else begin
                w_state = IDLE;
            end
            S_GAP: if (r_gcnt == '0) w_state = IDLE;
                   else w_gcnt = r_gcnt - 1'b1;
            default: w_state = IDLE;
        endcase
        w_head = MSB_FIRST ? w_sr[WIDTH-1] : w_sr[0];
    end
    assign bus.ready = r_ready;
    assign bus.a     = r_a;
    assign bus.valid = r_valid;
    assign bus.last  = r_last;
endmodule
